// File: rtl/tsense_post.sv
// tsense_post: post-processing for the temperature pulse counter.
// Boxcar moving average over D = 2^AVG_LOG2 window counts, valid/ready result
// output with sticky overrun flag, and a hysteretic over-temperature alarm.
//
// Optional feature macro: TSENSE_MINMAX_EN enables min/max result tracking.
// Without it min_o/max_o are tied to 8'hFF/8'h00.
//
// Ports:
//   clk          in   single clock, posedge
//   rst_n        in   asynchronous active-low reset
//   cnt_i        in   [7:0] completed window count
//   cnt_valid_i  in   one-cycle strobe qualifying cnt_i
//   temp_o       out  [7:0] averaged temperature code
//   temp_valid_o out  temp_o holds an unconsumed result
//   temp_ready_i in   consumer accepts on temp_valid_o & temp_ready_i
//   alarm_o      out  over-temperature flag with hysteresis
//   overrun_o    out  sticky: a result was replaced before being consumed
//   ovr_clr_i    in   clears overrun_o (a simultaneous set wins)
//   min_o        out  [7:0] minimum averaged code since reset
//   max_o        out  [7:0] maximum averaged code since reset
module tsense_post #(
   parameter int AVG_LOG2 = 2,
   parameter int ALARM_HI = 200,
   parameter int ALARM_LO = 180
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cnt_i,
   input  logic       cnt_valid_i,
   output logic [7:0] temp_o,
   output logic       temp_valid_o,
   input  logic       temp_ready_i,
   output logic       alarm_o,
   output logic       overrun_o,
   input  logic       ovr_clr_i,
   output logic [7:0] min_o,
   output logic [7:0] max_o
);

   localparam int D  = 1 << AVG_LOG2;
   localparam int SW = 8 + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] FILL_LAST = AVG_LOG2'(D - 1);
   localparam logic [AVG_LOG2-1:0] PTR_ONE   = AVG_LOG2'(1);
   localparam logic [7:0]          HI_CODE   = 8'(ALARM_HI);
   localparam logic [7:0]          LO_CODE   = 8'(ALARM_LO);

   typedef enum logic [0:0] {
      WARMUP = 1'b0,
      RUN    = 1'b1
   } state_t;

   state_t              state_r, state_s;
   logic [7:0]          buf_r [D];
   logic [AVG_LOG2-1:0] wr_ptr_r;
   logic [AVG_LOG2-1:0] fill_r;
   logic [SW-1:0]       sum_r, sum_s;
   logic                res_pend_r, res_pend_s;
   logic [7:0]          oldest_s;
   logic [7:0]          result_s;
   logic [7:0]          temp_r;
   logic                temp_valid_r;
   logic                alarm_r;
   logic                overrun_r;

   // Next state, oldest sample to retire, and whether this sample yields a result.
   always_comb begin
      state_s    = state_r;
      res_pend_s = 1'b0;
      oldest_s   = 8'h00;
      case (state_r)
         WARMUP: begin
            // Buffer slots are not yet part of the window, so nothing retires.
            oldest_s = 8'h00;
            if (cnt_valid_i && (fill_r == FILL_LAST)) begin
               state_s    = RUN;
               res_pend_s = 1'b1;
            end else begin
               state_s    = WARMUP;
               res_pend_s = 1'b0;
            end
         end
         RUN: begin
            // The write slot holds the sample that falls out of the window.
            oldest_s   = buf_r[wr_ptr_r];
            res_pend_s = cnt_valid_i;
            state_s    = RUN;
         end
         default: begin
            state_s    = WARMUP;
            res_pend_s = 1'b0;
            oldest_s   = 8'h00;
         end
      endcase
   end

   // Running window sum after adding the new sample and retiring the oldest.
   always_comb begin
      sum_s = sum_r + {{AVG_LOG2{1'b0}}, cnt_i} - {{AVG_LOG2{1'b0}}, oldest_s};
   end

   assign result_s = sum_r[SW-1:AVG_LOG2];

   // Sample stage: buffer, pointer, fill count, running sum and state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= WARMUP;
         wr_ptr_r   <= '0;
         fill_r     <= '0;
         sum_r      <= '0;
         res_pend_r <= 1'b0;
         for (int i = 0; i < D; i++) begin
            buf_r[i] <= 8'h00;
         end
      end else begin
         state_r    <= state_s;
         res_pend_r <= res_pend_s;
         if (cnt_valid_i) begin
            buf_r[wr_ptr_r] <= cnt_i;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            sum_r           <= sum_s;
            if (state_r == WARMUP) begin
               fill_r <= fill_r + PTR_ONE;
            end else begin
               fill_r <= fill_r;
            end
         end else begin
            wr_ptr_r <= wr_ptr_r;
            sum_r    <= sum_r;
            fill_r   <= fill_r;
         end
      end
   end

   // Result stage: output register, valid/ready handshake and alarm hysteresis.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         temp_r       <= 8'h00;
         temp_valid_r <= 1'b0;
         alarm_r      <= 1'b0;
      end else if (res_pend_r) begin
         // A load keeps valid high even when the old result is consumed now.
         temp_r       <= result_s;
         temp_valid_r <= 1'b1;
         if (result_s >= HI_CODE) begin
            alarm_r <= 1'b1;
         end else if (result_s <= LO_CODE) begin
            alarm_r <= 1'b0;
         end else begin
            alarm_r <= alarm_r;
         end
      end else if (temp_valid_r && temp_ready_i) begin
         temp_valid_r <= 1'b0;
      end else begin
         temp_valid_r <= temp_valid_r;
      end
   end

   // Sticky overrun: set on overwrite of an unconsumed result, set beats clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_r <= 1'b0;
      end else if (res_pend_r && temp_valid_r && !temp_ready_i) begin
         overrun_r <= 1'b1;
      end else if (ovr_clr_i) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

   assign temp_o       = temp_r;
   assign temp_valid_o = temp_valid_r;
   assign alarm_o      = alarm_r;
   assign overrun_o    = overrun_r;

`ifdef TSENSE_MINMAX_EN
   logic [7:0] min_r;
   logic [7:0] max_r;

   // Extreme tracking of every loaded result since reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_r <= 8'hFF;
         max_r <= 8'h00;
      end else if (res_pend_r) begin
         min_r <= (result_s < min_r) ? result_s : min_r;
         max_r <= (result_s > max_r) ? result_s : max_r;
      end else begin
         min_r <= min_r;
         max_r <= max_r;
      end
   end

   assign min_o = min_r;
   assign max_o = max_r;
`else
   assign min_o = 8'hFF;
   assign max_o = 8'h00;
`endif

endmodule
